// File: rtl/clock_pkg.sv
// Shared types and constants for the front-panel time/alarm setting controller.
package clock_pkg;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    T_HOUR = 3'd1,
    T_MIN  = 3'd2,
    T_SEC  = 3'd3,
    A_HOUR = 3'd4,
    A_MIN  = 3'd5
  } state_t;

  localparam int T_HOUR_OFS = 16;
  localparam int T_MIN_OFS  = 8;
  localparam int T_SEC_OFS  = 0;
  localparam int A_HOUR_OFS = 8;
  localparam int A_MIN_OFS  = 0;

  localparam logic [7:0] HOUR_LIM    = 8'h23;
  localparam logic [7:0] MIN_SEC_LIM = 8'h59;

  localparam logic [23:0] SET_TIME_RST   = 24'h120000;
  localparam logic [15:0] ALARM_TIME_RST = 16'h0700;

endpackage

// File: rtl/bcd2_inc.sv
// Two-digit BCD incrementer with wrap at a BCD limit; anything invalid maps to 00.
module bcd2_inc (
  input  logic [7:0] value,
  input  logic [7:0] limit,
  output logic [7:0] result
);

  logic valid;

  always_comb begin
    valid  = (value[3:0] <= 4'd9) && (value[7:4] <= 4'd9) && (value <= limit);
    result = 8'h00;
    if (valid && (value != limit)) begin
      if (value[3:0] == 4'd9) result = {value[7:4] + 4'd1, 4'd0};
      else                    result = {value[7:4], value[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel mode FSM: edits time/alarm fields in BCD, issues the time load strobe
// and a blink mask for the field under edit.
//
// state  | meaning
// RUN    | normal display; mode->edit time, alarm->edit alarm, inc->toggle alarm enable
// T_HOUR | editing set_time hours
// T_MIN  | editing set_time minutes
// T_SEC  | editing set_time seconds; mode loads time and returns to RUN
// A_HOUR | editing alarm hours
// A_MIN  | editing alarm minutes; mode enables alarm and returns to RUN
module time_set_ctrl #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_mode,
  input  logic        key_inc,
  input  logic        key_alarm,
  input  logic [23:0] cur_time,
  output logic [23:0] set_time,
  output logic        set_time_finish,
  output logic        clock_en,
  output logic [15:0] alarm_time,
  output logic [5:0]  blink_mask,
  output logic [2:0]  mode
);
  import clock_pkg::*;

  localparam int CW = $clog2(BLINK_DIV);

  state_t          state;
  logic            armed;
  logic [2:0]      key_prev;
  logic            act_mode, act_alarm, act_inc;
  logic [7:0]      fld_val, fld_lim, fld_next;
  logic [CW-1:0]   blink_cnt;
  logic            phase;
  logic            blink_clr;

  // The first edge after reset only loads key history, so a key held through reset is not a press.
  assign act_mode  = armed & key_mode  & ~key_prev[2];
  assign act_alarm = armed & key_alarm & ~key_prev[1] & ~act_mode;
  assign act_inc   = armed & key_inc   & ~key_prev[0] & ~act_mode & ~(armed & key_alarm & ~key_prev[1]);

  always_comb begin
    fld_val = 8'h00;
    fld_lim = MIN_SEC_LIM;
    case (state)
      T_HOUR: begin fld_val = set_time[T_HOUR_OFS +: 8];   fld_lim = HOUR_LIM; end
      T_MIN:  fld_val = set_time[T_MIN_OFS +: 8];
      T_SEC:  fld_val = set_time[T_SEC_OFS +: 8];
      A_HOUR: begin fld_val = alarm_time[A_HOUR_OFS +: 8]; fld_lim = HOUR_LIM; end
      A_MIN:  fld_val = alarm_time[A_MIN_OFS +: 8];
      default: fld_val = 8'h00;
    endcase
  end

  bcd2_inc u_bcd2_inc (
    .value  (fld_val),
    .limit  (fld_lim),
    .result (fld_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= RUN;
      armed           <= 1'b0;
      key_prev        <= 3'b000;
      set_time        <= SET_TIME_RST;
      alarm_time      <= ALARM_TIME_RST;
      clock_en        <= 1'b0;
      set_time_finish <= 1'b0;
    end else begin
      armed           <= 1'b1;
      key_prev        <= {key_mode, key_alarm, key_inc};
      set_time_finish <= 1'b0;
      case (state)
        RUN: begin
          if (act_mode) begin
            set_time <= cur_time;
            state    <= T_HOUR;
          end else if (act_alarm) begin
            state <= A_HOUR;
          end else if (act_inc) begin
            clock_en <= ~clock_en;
          end
        end
        T_HOUR: begin
          if (act_mode)     state <= T_MIN;
          else if (act_inc) set_time[T_HOUR_OFS +: 8] <= fld_next;
        end
        T_MIN: begin
          if (act_mode)     state <= T_SEC;
          else if (act_inc) set_time[T_MIN_OFS +: 8] <= fld_next;
        end
        T_SEC: begin
          if (act_mode) begin
            state           <= RUN;
            set_time_finish <= 1'b1;
          end else if (act_inc) begin
            set_time[T_SEC_OFS +: 8] <= fld_next;
          end
        end
        A_HOUR: begin
          if (act_mode)     state <= A_MIN;
          else if (act_inc) alarm_time[A_HOUR_OFS +: 8] <= fld_next;
        end
        A_MIN: begin
          if (act_mode) begin
            state    <= RUN;
            clock_en <= 1'b1;
          end else if (act_inc) begin
            alarm_time[A_MIN_OFS +: 8] <= fld_next;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Restart the blink on every visible change so the edited digits show at once.
  assign blink_clr = act_mode | (act_alarm & (state == RUN)) | (act_inc & (state != RUN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_clr) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    blink_mask = 6'b000000;
    case (state)
      T_HOUR, A_HOUR: blink_mask[5:4] = {2{phase}};
      T_MIN,  A_MIN:  blink_mask[3:2] = {2{phase}};
      T_SEC:          blink_mask[1:0] = {2{phase}};
      default:        blink_mask      = 6'b000000;
    endcase
  end

  assign mode = state;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Table-driven bench for time_set_ctrl; expected outputs go through a scoreboard queue.
module tb_time_set_ctrl;

  localparam int BLINK_DIV = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_mode, key_inc, key_alarm;
  logic [23:0] cur_time;
  logic [23:0] set_time;
  logic        set_time_finish;
  logic        clock_en;
  logic [15:0] alarm_time;
  logic [5:0]  blink_mask;
  logic [2:0]  mode;

  time_set_ctrl #(.BLINK_DIV(BLINK_DIV)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .key_mode        (key_mode),
    .key_inc         (key_inc),
    .key_alarm       (key_alarm),
    .cur_time        (cur_time),
    .set_time        (set_time),
    .set_time_finish (set_time_finish),
    .clock_en        (clock_en),
    .alarm_time      (alarm_time),
    .blink_mask      (blink_mask),
    .mode            (mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        km, ki, ka;
    logic [23:0] cur;
    logic [23:0] e_set;
    logic        e_fin;
    logic        e_ce;
    logic [15:0] e_al;
    logic [2:0]  e_md;
    logic        chk_blk;
    logic [5:0]  e_blk;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic        g_rst = 1'b0;
  logic [23:0] g_cur = 24'h235959;
  logic        g_chkb = 1'b1;
  logic [5:0]  g_blk = 6'b000000;

  task automatic add(input logic m, input logic i, input logic a, input logic [23:0] st,
                     input logic fin, input logic ce, input logic [15:0] al, input logic [2:0] md);
    vec_t v;
    v.rst = g_rst; v.km = m; v.ki = i; v.ka = a; v.cur = g_cur;
    v.e_set = st; v.e_fin = fin; v.e_ce = ce; v.e_al = al; v.e_md = md;
    v.chk_blk = g_chkb; v.e_blk = g_blk;
    tbl.push_back(v);
  endtask

  task automatic chk(input int idx, input string name, input logic [23:0] act, input logic [23:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL vec %0d %s: got %h expected %h", idx, name, act, req);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t e;
    rst_n = 1'b0; key_mode = 1'b0; key_inc = 1'b0; key_alarm = 1'b0; cur_time = 24'h235959;

    // reset state, then first time edit with hour wrap and blink
    g_rst = 1'b0;
    add(0,0,0, 24'h120000,0,0,16'h0700,3'd0);
    add(0,0,0, 24'h120000,0,0,16'h0700,3'd0);
    g_rst = 1'b1;
    add(0,0,0, 24'h120000,0,0,16'h0700,3'd0);
    add(0,0,0, 24'h120000,0,0,16'h0700,3'd0);
    add(1,0,0, 24'h235959,0,0,16'h0700,3'd1);
    add(0,0,0, 24'h235959,0,0,16'h0700,3'd1);
    add(0,1,0, 24'h005959,0,0,16'h0700,3'd1);
    for (int k = 1; k < BLINK_DIV; k++) add(0,0,0, 24'h005959,0,0,16'h0700,3'd1);
    g_blk = 6'b110000;
    add(0,0,0, 24'h005959,0,0,16'h0700,3'd1);
    g_blk = 6'b000000;
    add(1,0,0, 24'h005959,0,0,16'h0700,3'd2);
    add(0,0,0, 24'h005959,0,0,16'h0700,3'd2);
    add(1,0,0, 24'h005959,0,0,16'h0700,3'd3);
    add(0,0,0, 24'h005959,0,0,16'h0700,3'd3);
    add(1,0,0, 24'h005959,1,0,16'h0700,3'd0);
    add(0,0,0, 24'h005959,0,0,16'h0700,3'd0);

    // full time edit; cur_time changes after entry must not leak in
    g_cur = 24'h105830;
    add(1,0,0, 24'h105830,0,0,16'h0700,3'd1);
    g_cur = 24'h010203;
    add(0,0,0, 24'h105830,0,0,16'h0700,3'd1);
    add(0,1,0, 24'h115830,0,0,16'h0700,3'd1);
    add(0,0,0, 24'h115830,0,0,16'h0700,3'd1);
    add(0,1,0, 24'h125830,0,0,16'h0700,3'd1);
    add(0,0,0, 24'h125830,0,0,16'h0700,3'd1);
    add(0,1,0, 24'h135830,0,0,16'h0700,3'd1);
    add(0,0,0, 24'h135830,0,0,16'h0700,3'd1);
    add(1,0,0, 24'h135830,0,0,16'h0700,3'd2);
    add(0,0,0, 24'h135830,0,0,16'h0700,3'd2);
    add(1,0,0, 24'h135830,0,0,16'h0700,3'd3);
    add(0,0,0, 24'h135830,0,0,16'h0700,3'd3);
    add(0,1,0, 24'h135831,0,0,16'h0700,3'd3);
    add(0,0,0, 24'h135831,0,0,16'h0700,3'd3);
    add(1,0,0, 24'h135831,1,0,16'h0700,3'd0);
    add(0,0,0, 24'h135831,0,0,16'h0700,3'd0);
    add(0,0,0, 24'h135831,0,0,16'h0700,3'd0);

    // alarm edit with minute wrap past 59
    add(0,0,1, 24'h135831,0,0,16'h0700,3'd4);
    add(0,0,0, 24'h135831,0,0,16'h0700,3'd4);
    add(0,1,0, 24'h135831,0,0,16'h0800,3'd4);
    add(0,0,0, 24'h135831,0,0,16'h0800,3'd4);
    add(0,1,0, 24'h135831,0,0,16'h0900,3'd4);
    add(0,0,0, 24'h135831,0,0,16'h0900,3'd4);
    add(1,0,0, 24'h135831,0,0,16'h0900,3'd5);
    add(0,0,0, 24'h135831,0,0,16'h0900,3'd5);
    for (int k = 1; k <= 61; k++) begin
      add(0,1,0, 24'h135831,0,0,{8'h09, to_bcd(k % 60)},3'd5);
      add(0,0,0, 24'h135831,0,0,{8'h09, to_bcd(k % 60)},3'd5);
    end
    add(0,0,1, 24'h135831,0,0,16'h0901,3'd5);
    add(0,0,0, 24'h135831,0,0,16'h0901,3'd5);
    add(1,0,0, 24'h135831,0,1,16'h0901,3'd0);
    add(0,0,0, 24'h135831,0,1,16'h0901,3'd0);
    add(0,1,0, 24'h135831,0,0,16'h0901,3'd0);
    add(0,0,0, 24'h135831,0,0,16'h0901,3'd0);
    add(0,1,0, 24'h135831,0,1,16'h0901,3'd0);
    add(0,0,0, 24'h135831,0,1,16'h0901,3'd0);

    // held inc gives one increment; mode+inc together advances without incrementing
    g_cur = 24'h085959;
    add(1,0,0, 24'h085959,0,1,16'h0901,3'd1);
    add(0,0,0, 24'h085959,0,1,16'h0901,3'd1);
    add(0,1,0, 24'h095959,0,1,16'h0901,3'd1);
    g_chkb = 1'b0;
    for (int k = 0; k < 99; k++) add(0,1,0, 24'h095959,0,1,16'h0901,3'd1);
    add(0,0,0, 24'h095959,0,1,16'h0901,3'd1);
    g_chkb = 1'b1;
    add(1,1,0, 24'h095959,0,1,16'h0901,3'd2);
    add(0,0,0, 24'h095959,0,1,16'h0901,3'd2);
    add(1,0,0, 24'h095959,0,1,16'h0901,3'd3);
    add(0,0,0, 24'h095959,0,1,16'h0901,3'd3);
    add(1,0,0, 24'h095959,1,1,16'h0901,3'd0);
    add(0,0,0, 24'h095959,0,1,16'h0901,3'd0);

    // non-BCD seconds increment to 00
    g_cur = 24'h12347A;
    add(1,0,0, 24'h12347A,0,1,16'h0901,3'd1);
    add(0,0,0, 24'h12347A,0,1,16'h0901,3'd1);
    add(1,0,0, 24'h12347A,0,1,16'h0901,3'd2);
    add(0,0,0, 24'h12347A,0,1,16'h0901,3'd2);
    add(1,0,0, 24'h12347A,0,1,16'h0901,3'd3);
    add(0,0,0, 24'h12347A,0,1,16'h0901,3'd3);
    add(0,1,0, 24'h123400,0,1,16'h0901,3'd3);
    add(0,0,0, 24'h123400,0,1,16'h0901,3'd3);

    // reset while in T_MIN with mode held across reset release
    add(1,0,0, 24'h123400,1,1,16'h0901,3'd0);
    add(0,0,0, 24'h123400,0,1,16'h0901,3'd0);
    add(1,0,0, 24'h12347A,0,1,16'h0901,3'd1);
    add(0,0,0, 24'h12347A,0,1,16'h0901,3'd1);
    add(1,0,0, 24'h12347A,0,1,16'h0901,3'd2);
    g_rst = 1'b0;
    add(1,0,0, 24'h120000,0,0,16'h0700,3'd0);
    add(1,0,0, 24'h120000,0,0,16'h0700,3'd0);
    g_rst = 1'b1;
    add(1,0,0, 24'h120000,0,0,16'h0700,3'd0);
    add(1,0,0, 24'h120000,0,0,16'h0700,3'd0);
    add(0,0,0, 24'h120000,0,0,16'h0700,3'd0);
    add(1,0,0, 24'h12347A,0,0,16'h0700,3'd1);
    add(0,0,0, 24'h12347A,0,0,16'h0700,3'd1);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n     = tbl[i].rst;
      key_mode  = tbl[i].km;
      key_inc   = tbl[i].ki;
      key_alarm = tbl[i].ka;
      cur_time  = tbl[i].cur;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk(i, "set_time",   set_time,                e.e_set);
      chk(i, "finish",     24'(set_time_finish),    24'(e.e_fin));
      chk(i, "clock_en",   24'(clock_en),           24'(e.e_ce));
      chk(i, "alarm_time", 24'(alarm_time),         24'(e.e_al));
      chk(i, "mode",       24'(mode),               24'(e.e_md));
      if (e.chk_blk) chk(i, "blink_mask", 24'(blink_mask), 24'(e.e_blk));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Front-panel controller for the digital clock. It turns three debounced push-buttons into a mode state machine that edits the current time and the alarm time in BCD. It issues the one-cycle `set_time_finish` load strobe to the time-keeping block and drives the alarm enable and alarm digits. It sits between the board keys and the time-keeping/display blocks, and also outputs a blink mask so the display flashes the field being edited.

## Interface
- `BLINK_DIV`, default 25_000_000: clk cycles per blink half-period; minimum 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_mode`  in  1  debounced, clk-synchronous, high while pressed.
- `key_inc`  in  1  same conditioning as `key_mode`.
- `key_alarm`  in  1  same conditioning as `key_mode`.
- `cur_time`  in  24  live time, BCD {hour_shi, hour_ge, min_shi, min_ge, sec_shi, sec_ge}.
- `set_time`  out  24  edited time, same packing; registered.
- `set_time_finish`  out  1  one-cycle load strobe for `set_time`.
- `clock_en`  out  1  alarm enable level.
- `alarm_time`  out  16  BCD {hour_shi, hour_ge, min_shi, min_ge}.
- `blink_mask`  out  6  1 = blank digit; bit 5 = hour_shi … bit 0 = sec_ge.
- `mode`  out  3  current state encoding, for debug/LEDs.

## Operation
- A press is a rising edge of a key: the current sample is 1 and the previous registered sample is 0. Holding a key produces exactly one press.
- States and encodings: RUN=0, T_HOUR=1, T_MIN=2, T_SEC=3, A_HOUR=4, A_MIN=5. Encodings 6–7 are illegal and recover to RUN.
- RUN:
  - mode press: load the working register `set_time` from `cur_time`, then go to T_HOUR.
  - alarm press: go to A_HOUR.
  - inc press: toggle `clock_en`.
- T_HOUR → T_MIN → T_SEC on mode presses.
- T_SEC + mode press: go to RUN and assert `set_time_finish` for exactly 1 cycle; `set_time` holds its value afterwards.
- A_HOUR → A_MIN on mode press.
- A_MIN + mode press: go to RUN and set `clock_en`=1.
- In the alarm states, alarm presses are ignored.
- An inc press in an edit state increments the edited two-digit BCD field, using the `set_time` field in T_* states and the `alarm_time` field in A_* states:
  - hours 00..23 wrap to 00;
  - minutes and seconds 00..59 wrap to 00;
  - any out-of-range or non-BCD field value increments to 00.
- No carry between fields.
- Simultaneous presses in one cycle: mode > alarm > inc. Only the highest-priority press acts; the others are discarded, not queued.
- Blink:
  - Counter runs 0..BLINK_DIV-1 and toggles `phase` at wrap.
  - Counter and `phase` clear to 0 on any state change or increment, so an edited digit is shown immediately.
  - In an edit state, the two bits of the edited field follow `phase`; all other bits are 0.
  - In RUN, `blink_mask`=0.

## Timing
- Reset values:
  - state=RUN
  - `set_time`=0x120000
  - `alarm_time`=0x0700
  - `clock_en`=0
  - `set_time_finish`=0
  - `blink_mask`=0
  - `mode`=0
  - key history=0, so a key held through reset release produces no press.
- Latency: a key first sampled high at edge N has its effect visible on all outputs after edge N; `set_time_finish` is high for the cycle N..N+1 only.
- `set_time` is stable from the entry to T_HOUR through the `set_time_finish` cycle and afterwards.
- Reset mid-edit: abandon the edit. No `set_time_finish` pulse is issued, and all registers return to their reset values.
- `cur_time` is sampled only on the RUN→T_HOUR edge.

## Structure
- Package `clock_pkg`:
  - state enum;
  - field bit offsets (HOUR=16, MIN=8, SEC=0 within `set_time`; HOUR=8, MIN=0 within `alarm_time`);
  - field limits 23/59;
  - reset constants 0x120000 / 0x0700.
- Sub-module `bcd2_inc`: combinational two-digit BCD incrementer. Inputs: 8-bit value, 8-bit BCD limit. Output: next value. One instance, muxed by state.

## Test plan
- Reset, then T_HOUR with `cur_time`=0x235959: mode press → `set_time`=0x235959, `mode`=1; one inc → `set_time`=0x005959; `blink_mask`=6'b110000 after BLINK_DIV cycles.
- Full time edit: from RUN, mode press, 3 inc, mode, mode, 1 inc, mode → single-cycle `set_time_finish`; `set_time` field increments applied per field; `mode`=0.
- Alarm edit: alarm press, inc ×2, mode, inc ×61 → `alarm_time`=0x0901, `clock_en`=1 after the final mode press.
- Held key for 100 cycles → exactly one increment. Mode and inc pressed in the same cycle → state advances, value unchanged.
- Reset asserted in T_MIN → no `set_time_finish`; all outputs at reset values; a key held across reset release is ignored.
- T_SEC with `cur_time` seconds = 0x7A (non-BCD), inc press → seconds field = 0x00.
